// File: rtl/msgdec_pkg.sv
// Shared types and constants for the message rotate-decoder slice.
//   DATA_W         : decoded byte width
//   ROT_W          : rotation amount width
//   msgdec_state_t : decoder FSM state encoding
package msgdec_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ROT_W  = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } msgdec_state_t;

endpackage : msgdec_pkg

// File: rtl/msg_rot_decoder_barrel_shifter.sv
// Combinational right-rotate of one byte by a 4-bit amount.
// Amounts 8..15 alias to 0..7 because the byte pattern repeats every 8 bits.
// Ports:
//   data_i : byte to rotate
//   rot_i  : rotation amount
//   data_o : data_i rotated right by rot_i mod 8
import msgdec_pkg::*;

module BarrelShifter (
  input  logic [DATA_W-1:0] data_i,
  input  logic [ROT_W-1:0]  rot_i,
  output logic [DATA_W-1:0] data_o
);

  localparam int unsigned TRIPLE_W = 3 * DATA_W;

  logic [TRIPLE_W-1:0] triple_c;
  logic [TRIPLE_W-1:0] shifted_c;

  // Three copies cover every window start 0..15 without a modulo.
  assign triple_c  = {data_i, data_i, data_i};
  assign shifted_c = triple_c >> rot_i;
  assign data_o    = shifted_c[DATA_W-1:0];

endmodule : BarrelShifter

// File: rtl/msg_rot_decoder.sv
// Sequential message decoder: on start, reads len bytes from src_base,
// right-rotates each through a BarrelShifter and writes it to dst_base,
// then pulses done. Each byte costs three cycles (READ, WAIT, WRITE).
// Optional feature: define ROLLING_KEY_EN to make byte i use key+i mod 16
// instead of the fixed key.
// Ports:
//   clk, rst_n                         : clock, async active-low reset
//   start, key, src_base, dst_base, len: job launch and parameters
//   rd_en, rd_addr, rd_data            : source memory read port
//   wr_en, wr_addr, wr_data            : destination memory write port
//   busy, done, count                  : status
import msgdec_pkg::*;

module msg_rot_decoder #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ROT_W-1:0]  key,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [LEN_W-1:0]  len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  count
);

  msgdec_state_t     state_q,     state_d;
  logic [ROT_W-1:0]  key_q,       key_d;
  logic [ADDR_W-1:0] src_base_q,  src_base_d;
  logic [ADDR_W-1:0] dst_base_q,  dst_base_d;
  logic [LEN_W-1:0]  len_q,       len_d;
  logic [LEN_W-1:0]  idx_q,       idx_d;
  logic [LEN_W-1:0]  count_q,     count_d;
  logic [ADDR_W-1:0] rd_addr_q,   rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
  logic [DATA_W-1:0] wr_data_q,   wr_data_d;

  logic [ROT_W-1:0]  rot_c;
  logic [DATA_W-1:0] decoded_c;
  logic [LEN_W-1:0]  idx_inc_c;

  // Rotation amount for the byte currently in flight.
`ifdef ROLLING_KEY_EN
  assign rot_c = key_q + ROT_W'(idx_q);
`else
  assign rot_c = key_q;
`endif

  BarrelShifter u_barrel_shifter (
    .data_i (rd_data),
    .rot_i  (rot_c),
    .data_o (decoded_c)
  );

  assign idx_inc_c = idx_q + LEN_W'(1);

  // State register and job fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      key_q      <= '0;
      src_base_q <= '0;
      dst_base_q <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      count_q    <= '0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      src_base_q <= src_base_d;
      dst_base_q <= dst_base_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    src_base_d = src_base_q;
    dst_base_d = dst_base_q;
    len_d      = len_q;
    idx_d      = idx_q;
    count_d    = count_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          key_d      = key;
          src_base_d = src_base;
          dst_base_d = dst_base;
          len_d      = len;
          idx_d      = '0;
          count_d    = '0;
          // First read address goes out with the READ state itself.
          rd_addr_d  = src_base;
          state_d    = (len == '0) ? DONE : READ;
        end
      end
      READ: begin
        state_d = WAIT;
      end
      WAIT: begin
        wr_data_d = decoded_c;
        wr_addr_d = dst_base_q + ADDR_W'(idx_q);
        state_d   = WRITE;
      end
      WRITE: begin
        idx_d     = idx_inc_c;
        count_d   = count_q + LEN_W'(1);
        rd_addr_d = src_base_q + ADDR_W'(idx_inc_c);
        state_d   = (idx_inc_c == len_q) ? DONE : READ;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes decode straight from the state register.
  assign rd_en   = (state_q == READ);
  assign wr_en   = (state_q == WRITE);
  assign done    = (state_q == DONE);
  assign busy    = (state_q != IDLE);
  assign rd_addr = rd_addr_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign count   = count_q;

endmodule : msg_rot_decoder

// File: tb/tb_msg_rot_decoder.sv
// Bench for msg_rot_decoder: directed and random jobs against a
// memory-level reference model of the decode.
module tb_msg_rot_decoder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] key;
  logic [9:0] src_base;
  logic [9:0] dst_base;
  logic [9:0] len;
  logic       rd_en;
  logic [9:0] rd_addr;
  logic [7:0] rd_data;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
  logic [9:0] count;

  logic [7:0] src_mem [1024];
  logic [7:0] dst_mem [1024];

  int pass_cnt;
  int total_cnt;

  msg_rot_decoder #(.ADDR_W(10), .LEN_W(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key      (key),
    .src_base (src_base),
    .dst_base (dst_base),
    .len      (len),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source memory: one-cycle read latency, garbage when not read.
  always @(posedge clk) begin
    if (rd_en) rd_data <= src_mem[rd_addr];
    else       rd_data <= 8'($urandom);
  end

  always @(posedge clk) begin
    if (wr_en) dst_mem[wr_addr] <= wr_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Decoded value of byte i of a job: right rotate by the per-byte amount.
  function automatic logic [7:0] model_byte(input int k, input int i, input int sb);
    int b;
    int r;
    b = int'(src_mem[(sb + i) % 1024]);
`ifdef ROLLING_KEY_EN
    r = (k + i) % 16;
`else
    r = k;
`endif
    r = r % 8;
    return 8'(((b * 257) >> r) & 255);
  endfunction

  // Runs one job from start, checking every cycle. busy_cyc: cycle in which
  // a stray start is pulsed (0 = none). rst_cyc: cycle in which reset hits.
  task automatic run_job(input logic [3:0] k, input logic [9:0] sb, input logic [9:0] db,
                         input logic [9:0] n, input int busy_cyc, input int rst_cyc);
    int nn;
    int ki;
    int sbi;
    int dbi;
    int last;
    int i;
    logic [3:0] ev;
    nn   = int'(n);
    ki   = int'(k);
    sbi  = int'(sb);
    dbi  = int'(db);
    last = (rst_cyc > 0) ? rst_cyc : 3 * nn + 2;
    @(negedge clk);
    key = k; src_base = sb; dst_base = db; len = n; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= last; c++) begin
      if (c > 1) @(posedge clk);
      #1;
      ev[3] = (c <= 3 * nn + 1);
      ev[2] = (c <= 3 * nn) && ((c - 1) % 3 == 0);
      ev[1] = (c <= 3 * nn) && (c % 3 == 0);
      ev[0] = (c == 3 * nn + 1);
      check($sformatf("busy_rd_wr_done@c%0d", c), 32'({busy, rd_en, wr_en, done}), 32'(ev));
      check($sformatf("count@c%0d", c), 32'(count), 32'((c - 1) / 3 < nn ? (c - 1) / 3 : nn));
      if (ev[2]) begin
        i = (c - 1) / 3;
        check($sformatf("rd_addr@c%0d", c), 32'(rd_addr), 32'((sbi + i) % 1024));
      end
      if (ev[1]) begin
        i = (c - 3) / 3;
        check($sformatf("wr_addr@c%0d", c), 32'(wr_addr), 32'((dbi + i) % 1024));
        check($sformatf("wr_data@c%0d", c), 32'(wr_data), 32'(model_byte(ki, i, sbi)));
      end
      if (c == rst_cyc) begin
        rst_n = 1'b0;
        #1;
        check("reset_outputs", 32'({busy, rd_en, wr_en, done, rd_addr, wr_addr, wr_data}), 32'd0);
        check("reset_count", 32'(count), 32'd0);
      end
      start = (c == busy_cyc);
      if (c == busy_cyc) begin
        key = 4'($urandom); src_base = 10'($urandom); dst_base = 10'($urandom);
        len = 10'($urandom_range(1, 9));
      end
    end
    start = 1'b0;
    if (rst_cyc > 0) begin
      @(negedge clk);
      rst_n = 1'b1;
      check("partial_write_kept", 32'(dst_mem[dbi % 1024]), 32'(model_byte(ki, 0, sbi)));
      @(negedge clk);
      check("idle_after_reset", 32'({busy, count}), 32'd0);
    end else begin
      for (int j = 0; j < nn; j++)
        check($sformatf("dst_mem[%0d]", j), 32'(dst_mem[(dbi + j) % 1024]),
              32'(model_byte(ki, j, sbi)));
    end
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    rst_n = 1'b0;
    start = 1'b0;
    key = '0; src_base = '0; dst_base = '0; len = '0;
    for (int a = 0; a < 1024; a++) begin
      src_mem[a] = 8'($urandom);
      dst_mem[a] = 8'h00;
    end

    // Reset state.
    #12;
    check("reset_state", 32'({busy, rd_en, wr_en, done, rd_addr, wr_addr, wr_data, count}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single byte, key 1: 0xF1 -> 0xF8.
    src_mem[16] = 8'hF1;
    run_job(4'd1, 10'd16, 10'd200, 10'd1, 0, 0);
    check("single_value", 32'(dst_mem[200]), 32'h0F8);

    // Fixed key 4, three bytes.
    src_mem[32] = 8'hF1; src_mem[33] = 8'h0F; src_mem[34] = 8'h80;
    run_job(4'd4, 10'd32, 10'd300, 10'd3, 0, 0);
`ifndef ROLLING_KEY_EN
    check("fixed3_b0", 32'(dst_mem[300]), 32'h01F);
    check("fixed3_b1", 32'(dst_mem[301]), 32'h0F0);
    check("fixed3_b2", 32'(dst_mem[302]), 32'h008);
`endif

`ifdef ROLLING_KEY_EN
    // Rolling key wraps 15 -> 0 -> 1.
    src_mem[48] = 8'hF1; src_mem[49] = 8'hF1; src_mem[50] = 8'hF1;
    run_job(4'd15, 10'd48, 10'd400, 10'd3, 0, 0);
    check("roll_b0", 32'(dst_mem[400]), 32'h0E3);
    check("roll_b1", 32'(dst_mem[401]), 32'h0F1);
    check("roll_b2", 32'(dst_mem[402]), 32'h0F8);
`endif

    // Zero length, then a stray start while busy.
    run_job(4'd3, 10'd0, 10'd0, 10'd0, 0, 0);
    run_job(4'd2, 10'd64, 10'd500, 10'd2, 3, 0);

    // Start during DONE is ignored.
    run_job(4'd5, 10'd70, 10'd510, 10'd1, 4, 0);

    // Address wrap at the top of memory.
    run_job(4'd6, 10'd1023, 10'd1023, 10'd2, 0, 0);

    // Reset mid-job.
    run_job(4'd7, 10'd80, 10'd600, 10'd4, 0, 5);

    // Random jobs.
    for (int t = 0; t < 10; t++) begin
      run_job(4'($urandom), 10'($urandom), 10'($urandom), 10'($urandom_range(1, 7)),
              (t % 3 == 0) ? int'($urandom_range(2, 6)) : 0, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_msg_rot_decoder
